spi_mem_writer_burst: RTL and testbench

SPI-slave burst writer placed between the SPI front end and a sample/configuration RAM. It receives an optional address header, then a stream of DW-bit words. Each completed word produces a one-cycle write strobe with data and address. The address auto-increments and either wraps or stops at a configurable depth. A mode input chooses between a header-loaded address and continuing from the previous transaction.

---
 rtl/spi_mem_writer_burst.sv | 165 ++++++++++++++++
 tb/tb_spi_mem_writer_burst.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_writer_burst.sv
// SPI-slave burst writer: optional address header, then DW-bit words, each
// emitted as a one-cycle write strobe with an auto-incrementing address.
module spi_mem_writer_burst #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 2**AW,
  parameter int WRAP  = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          sel,
  input  logic          rising,
  input  logic          falling,
  input  logic          si,
  input  logic          reset_flag,
  input  logic          mode,
  output logic          so,
  output logic          write_enable_out,
  output logic [DW-1:0] data,
  output logic [AW-1:0] addr,
  output logic [AW:0]   word_count,
  output logic          overflow,
  output logic          busy
);

  localparam int HDR_BITS = 8 * ((AW + 7) / 8);
  localparam int SW       = (HDR_BITS > DW) ? HDR_BITS : DW;
  localparam int CW       = $clog2(SW + 1);
  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LAST_L   = (AW+1)'(DEPTH - 1);
  localparam logic [CW-1:0] HDR_LAST = CW'(HDR_BITS - 1);
  localparam logic [CW-1:0] DW_LAST  = CW'(DW - 1);
  localparam logic [AW:0]   WC_MAX   = {(AW+1){1'b1}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_DATA = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          so_q, so_d;
  logic          we_q, we_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   wc_q, wc_d;
  logic          ov_q, ov_d;
  logic          exh_q, exh_d;
  logic          busy_q, busy_d;
  logic          shift_s;
  logic [SW-1:0] sr_shift_s;
  logic [AW-1:0] hdr_s;

  assign shift_s    = sel && rising && !reset_flag;
  assign sr_shift_s = {sr_q[SW-2:0], si};

  // State register and all datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      so_q    <= 1'b0;
      we_q    <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      wc_q    <= '0;
      ov_q    <= 1'b0;
      exh_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      so_q    <= so_d;
      we_q    <= we_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wc_q    <= wc_d;
      ov_q    <= ov_d;
      exh_q   <= exh_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: header/word assembly, strobe generation, address advance.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    data_d  = data_q;
    addr_d  = addr_q;
    wc_d    = wc_q;
    ov_d    = ov_q;
    exh_d   = exh_q;
    hdr_s   = sr_shift_s[AW-1:0];

    // Echo uses the pre-shift MSB even when a shift happens on the same edge.
    if (sel && falling) so_d = sr_q[SW-1];
    else                so_d = so_q;

    // The address advances on the edge that ends each strobe cycle.
    if (we_q) begin
      if ({1'b0, addr_q} < LAST_L) addr_d = addr_q + AW'(1);
      else if (WRAP != 0)          addr_d = '0;
      else                         exh_d  = 1'b1;
    end else begin
      addr_d = addr_q;
    end

    if (reset_flag) begin
      cnt_d   = '0;
      sr_d    = '0;
      wc_d    = '0;
      ov_d    = 1'b0;
      exh_d   = 1'b0;
      state_d = mode ? S_DATA : S_HDR;
    end else if (shift_s) begin
      case (state_q)
        S_HDR: begin
          sr_d = sr_shift_s;
          if (cnt_q == HDR_LAST) begin
            addr_d  = ({1'b0, hdr_s} >= DEPTH_L) ? '0 : hdr_s;
            cnt_d   = '0;
            state_d = S_DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          sr_d = sr_shift_s;
          if (cnt_q == DW_LAST) begin
            cnt_d = '0;
            if (exh_q) begin
              ov_d = 1'b1;
            end else begin
              data_d = sr_shift_s[DW-1:0];
              we_d   = 1'b1;
              if (wc_q != WC_MAX) wc_d = wc_q + (AW+1)'(1);
              else                wc_d = wc_q;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          sr_d  = sr_q;
          cnt_d = cnt_q;
        end
      endcase
    end else begin
      sr_d = sr_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign so               = so_q;
  assign write_enable_out = we_q;
  assign data             = data_q;
  assign addr             = addr_q;
  assign word_count       = wc_q;
  assign overflow         = ov_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_spi_mem_writer_burst.sv
// Directed bench for spi_mem_writer_burst: four parameterisations share the
// serial stimulus, each with its own chip-select and transaction-start strobe.
module tb_spi_mem_writer_burst;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rising = 1'b0, falling = 1'b0, si = 1'b0, mode = 1'b0;
  logic [3:0] sel = 4'b0000;
  logic [3:0] rf  = 4'b0000;

  int checks = 0;
  int failures = 0;

  logic so0, we0, ov0, busy0;
  logic [7:0] data0, addr0;
  logic [8:0] wc0;
  logic so1, we1, ov1, busy1;
  logic [15:0] data1;
  logic [7:0] addr1;
  logic [8:0] wc1;
  logic so2, we2, ov2, busy2;
  logic [7:0] data2, addr2;
  logic [8:0] wc2;
  logic so3, we3, ov3, busy3;
  logic [7:0] data3, addr3;
  logic [8:0] wc3;

  logic [15:0] qa0[$], qd0[$], qa1[$], qd1[$], qa2[$], qd2[$], qa3[$], qd3[$];

  always #5 clk = ~clk;

  spi_mem_writer_burst #(.AW(8), .DW(8), .DEPTH(256), .WRAP(1)) u0 (
    .clk(clk), .reset_n(reset_n), .sel(sel[0]), .rising(rising), .falling(falling),
    .si(si), .reset_flag(rf[0]), .mode(mode), .so(so0), .write_enable_out(we0),
    .data(data0), .addr(addr0), .word_count(wc0), .overflow(ov0), .busy(busy0));

  spi_mem_writer_burst #(.AW(8), .DW(16), .DEPTH(4), .WRAP(1)) u1 (
    .clk(clk), .reset_n(reset_n), .sel(sel[1]), .rising(rising), .falling(falling),
    .si(si), .reset_flag(rf[1]), .mode(mode), .so(so1), .write_enable_out(we1),
    .data(data1), .addr(addr1), .word_count(wc1), .overflow(ov1), .busy(busy1));

  spi_mem_writer_burst #(.AW(8), .DW(8), .DEPTH(4), .WRAP(0)) u2 (
    .clk(clk), .reset_n(reset_n), .sel(sel[2]), .rising(rising), .falling(falling),
    .si(si), .reset_flag(rf[2]), .mode(mode), .so(so2), .write_enable_out(we2),
    .data(data2), .addr(addr2), .word_count(wc2), .overflow(ov2), .busy(busy2));

  spi_mem_writer_burst #(.AW(8), .DW(8), .DEPTH(64), .WRAP(1)) u3 (
    .clk(clk), .reset_n(reset_n), .sel(sel[3]), .rising(rising), .falling(falling),
    .si(si), .reset_flag(rf[3]), .mode(mode), .so(so3), .write_enable_out(we3),
    .data(data3), .addr(addr3), .word_count(wc3), .overflow(ov3), .busy(busy3));

  // Record every write strobe seen on each instance.
  always @(negedge clk) begin
    if (we0) begin qa0.push_back({8'h00, addr0}); qd0.push_back({8'h00, data0}); end
    if (we1) begin qa1.push_back({8'h00, addr1}); qd1.push_back(data1); end
    if (we2) begin qa2.push_back({8'h00, addr2}); qd2.push_back({8'h00, data2}); end
    if (we3) begin qa3.push_back({8'h00, addr3}); qd3.push_back({8'h00, data3}); end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_txn(input int k, input logic m);
    @(negedge clk);
    mode  = m;
    rf[k] = 1'b1;
    @(negedge clk);
    rf[k] = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    si = b; rising = 1'b1; falling = 1'b0;
    @(negedge clk);
    rising = 1'b0; falling = 1'b1;
    @(negedge clk);
    falling = 1'b0;
  endtask

  task automatic send_word(input int width, input logic [15:0] value);
    for (int i = width - 1; i >= 0; i--) send_bit(value[i]);
  endtask

  task automatic clear_queues();
    qa0.delete(); qd0.delete(); qa1.delete(); qd1.delete();
    qa2.delete(); qd2.delete(); qa3.delete(); qd3.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_we",   {31'd0, we0},   32'd0);
    check_eq("rst_data", {24'd0, data0}, 32'd0);
    check_eq("rst_addr", {24'd0, addr0}, 32'd0);
    check_eq("rst_wc",   {23'd0, wc0},   32'd0);
    check_eq("rst_ov",   {31'd0, ov0},   32'd0);
    check_eq("rst_busy", {31'd0, busy0}, 32'd0);
    check_eq("rst_so",   {31'd0, so0},   32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_busy", {31'd0, busy0}, 32'd0);

    // Header 0x10 then 0xA5, 0x3C.
    sel = 4'b0001;
    clear_queues();
    start_txn(0, 1'b0);
    check_eq("t1_busy", {31'd0, busy0}, 32'd1);
    send_word(8, 16'h0010);
    send_word(8, 16'h00A5);
    send_word(8, 16'h003C);
    repeat (2) @(negedge clk);
    check_eq("t1_cnt",   qa0.size(), 32'd2);
    check_eq("t1_a0",    {16'd0, qa0[0]}, 32'h10);
    check_eq("t1_d0",    {16'd0, qd0[0]}, 32'hA5);
    check_eq("t1_a1",    {16'd0, qa0[1]}, 32'h11);
    check_eq("t1_d1",    {16'd0, qd0[1]}, 32'h3C);
    check_eq("t1_wc",    {23'd0, wc0},    32'd2);
    check_eq("t1_so",    {31'd0, so0},    32'd0);

    // Continue-address transaction: no header, resumes at 0x12.
    clear_queues();
    start_txn(0, 1'b1);
    check_eq("t4_wc_clr", {23'd0, wc0}, 32'd0);
    send_word(8, 16'h005A);
    repeat (2) @(negedge clk);
    check_eq("t4_cnt", qa0.size(), 32'd1);
    check_eq("t4_a0",  {16'd0, qa0[0]}, 32'h12);
    check_eq("t4_d0",  {16'd0, qd0[0]}, 32'h5A);
    check_eq("t4_wc",  {23'd0, wc0},    32'd1);

    // Abort after 5 data bits, then header 0x40 and byte 0x77.
    clear_queues();
    start_txn(0, 1'b0);
    send_word(8, 16'h0020);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    start_txn(0, 1'b0);
    send_word(8, 16'h0040);
    send_word(8, 16'h0077);
    repeat (2) @(negedge clk);
    check_eq("t5_cnt",  qa0.size(), 32'd1);
    check_eq("t5_a0",   {16'd0, qa0[0]}, 32'h40);
    check_eq("t5_d0",   {16'd0, qd0[0]}, 32'h77);
    check_eq("t5_addr", {24'd0, addr0},  32'h41);

    // DW=16, DEPTH=4, WRAP=1, header 3.
    sel = 4'b0010;
    clear_queues();
    start_txn(1, 1'b0);
    send_word(8, 16'h0003);
    send_word(16, 16'h1234);
    send_word(16, 16'hBEEF);
    send_word(16, 16'h0F0F);
    repeat (2) @(negedge clk);
    check_eq("t2_cnt", qa1.size(), 32'd3);
    check_eq("t2_a0",  {16'd0, qa1[0]}, 32'd3);
    check_eq("t2_a1",  {16'd0, qa1[1]}, 32'd0);
    check_eq("t2_a2",  {16'd0, qa1[2]}, 32'd1);
    check_eq("t2_d1",  {16'd0, qd1[1]}, 32'hBEEF);
    check_eq("t2_d2",  {16'd0, qd1[2]}, 32'h0F0F);
    check_eq("t2_ov",  {31'd0, ov1},    32'd0);
    check_eq("t2_wc",  {23'd0, wc1},    32'd3);

    // DEPTH=4, WRAP=0, header 2, four words: only two land.
    sel = 4'b0100;
    clear_queues();
    start_txn(2, 1'b0);
    send_word(8, 16'h0002);
    send_word(8, 16'h0011);
    send_word(8, 16'h0022);
    check_eq("t3_ov_early", {31'd0, ov2}, 32'd0);
    send_word(8, 16'h0033);
    send_word(8, 16'h0044);
    repeat (2) @(negedge clk);
    check_eq("t3_cnt",  qa2.size(), 32'd2);
    check_eq("t3_a0",   {16'd0, qa2[0]}, 32'd2);
    check_eq("t3_d0",   {16'd0, qd2[0]}, 32'h11);
    check_eq("t3_a1",   {16'd0, qa2[1]}, 32'd3);
    check_eq("t3_d1",   {16'd0, qd2[1]}, 32'h22);
    check_eq("t3_ov",   {31'd0, ov2},    32'd1);
    check_eq("t3_wc",   {23'd0, wc2},    32'd2);
    check_eq("t3_addr", {24'd0, addr2},  32'd3);

    // DEPTH=64: out-of-range header 0x80 loads address 0.
    sel = 4'b1000;
    clear_queues();
    start_txn(3, 1'b0);
    send_word(8, 16'h0010);
    send_word(8, 16'h0001);
    repeat (2) @(negedge clk);
    check_eq("t6_pre_addr", {24'd0, addr3}, 32'h11);
    start_txn(3, 1'b0);
    send_word(8, 16'h0080);
    check_eq("t6_addr", {24'd0, addr3}, 32'd0);
    send_word(8, 16'h0099);
    repeat (2) @(negedge clk);
    check_eq("t6_cnt", qa3.size(), 32'd2);
    check_eq("t6_a1",  {16'd0, qa3[1]}, 32'd0);
    check_eq("t6_d1",  {16'd0, qd3[1]}, 32'h99);

    // Asynchronous reset mid-word.
    sel = 4'b0001;
    clear_queues();
    start_txn(0, 1'b0);
    send_word(8, 16'h0005);
    send_word(8, 16'h00FF);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    check_eq("t7_pre_data", {24'd0, data0}, 32'hFF);
    check_eq("t7_pre_so",   {31'd0, so0},   32'd1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t7_data", {24'd0, data0}, 32'd0);
    check_eq("t7_addr", {24'd0, addr0}, 32'd0);
    check_eq("t7_wc",   {23'd0, wc0},   32'd0);
    check_eq("t7_busy", {31'd0, busy0}, 32'd0);
    check_eq("t7_so",   {31'd0, so0},   32'd0);
    check_eq("t7_we",   {31'd0, we0},   32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    clear_queues();
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    repeat (2) @(negedge clk);
    check_eq("t7_idle_busy", {31'd0, busy0}, 32'd0);
    check_eq("t7_no_write",  qa0.size(),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
